// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// Holds the FSM state encoding and the default fairness bounds.
package imem_port_arbiter_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_WAIT  = 8;
    localparam int DEF_BURST_MAX = 4;

    // Counter width for a bound, never narrower than one bit
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/imem_arb_perf.sv
// Performance counters for the instruction-memory port arbiter.
// Only instantiated when IMEM_ARB_PERF_EN is defined.
module imem_arb_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        grant,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_grant_cnt
);

    // Free-running wrapping counters of stall cycles and loader grants
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_grant_cnt <= '0;
        end else begin
            if (stall)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (grant)
                perf_grant_cnt <= perf_grant_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port IMEM between the fetch stage and the loader.
// Define IMEM_ARB_PERF_EN to add the stall/grant performance counters.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_stall,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_grant_cnt
`endif
);

    localparam int WAIT_W  = cnt_w(MAX_WAIT);
    localparam int BURST_W = cnt_w(BURST_MAX);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    arb_state_e         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic load_on;
    logic grant;
    logic burst_done;

    // Reset gates the outputs so a write in the reset cycle is dropped
    assign load_on    = (state == LOAD) && rst_n;
    assign grant      = (state == FETCH) && ld_valid
                     && (!fetch_req || wait_cnt == WAIT_LAST);
    // >= keeps the bound even if the count wrapped while the CPU was halted
    assign burst_done = fetch_req && load_on && ld_valid
                     && (burst_cnt >= BURST_LAST);

    assign fetch_stall = load_on && fetch_req;
    assign ld_ready    = load_on;
    assign mem_we      = load_on && ld_valid;
    assign mem_addr    = load_on ? ld_addr : fetch_addr;
    assign mem_wdata   = ld_data;

    // Ownership FSM with starvation and burst counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (grant) begin
                        state     <= LOAD;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (ld_valid && fetch_req) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (!ld_valid || burst_done) begin
                        state     <= FETCH;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
                default: begin
                    state     <= FETCH;
                    wait_cnt  <= '0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef IMEM_ARB_PERF_EN
    imem_arb_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (fetch_stall),
        .grant          (grant),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_grant_cnt (perf_grant_cnt)
    );
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural IMEM model.
// Perf counter checks are included when IMEM_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_stall;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_grant_cnt;
`endif

    logic [15:0] ram [0:4095];
    logic [15:0] ram_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    imem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // IMEM: asynchronous read, synchronous write
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr[11:0]] <= mem_wdata;
    end
    assign ram_rdata = ram[mem_addr[11:0]];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0010;
        ld_valid   = 1'b0;
        ld_addr    = 16'h0000;
        ld_data    = 16'h0000;
        nxt();
        nxt();
        smp();
        chk("rst_hold_we", mem_we, 0);
        chk("rst_hold_addr", mem_addr, 16'h0010);
        nxt();

        // reset released
        rst_n = 1'b1;
        smp();
        chk("rst_addr", mem_addr, 16'h0010);
        chk("rst_we", mem_we, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_ready", ld_ready, 0);
`ifdef IMEM_ARB_PERF_EN
        chk("rst_perf_stall", perf_stall_cnt, 0);
        chk("rst_perf_grant", perf_grant_cnt, 0);
`endif
        nxt();

        // starvation bound: 8 waiting cycles, then 4 writes
        ld_valid = 1'b1;
        ld_addr  = 16'h0040;
        ld_data  = 16'hA000;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("starve_wait_ready", ld_ready, 0);
            chk("starve_wait_stall", fetch_stall, 0);
            nxt();
        end
        for (int k = 0; k < 4; k++) begin
            ld_data = 16'hA000 + 16'(k);
            smp();
            chk("starve_ready", ld_ready, 1);
            chk("starve_stall", fetch_stall, 1);
            chk("starve_we", mem_we, 1);
            chk("starve_addr", mem_addr, 16'h0040);
            nxt();
        end
        smp();
        chk("starve_gap_stall", fetch_stall, 0);
        chk("starve_gap_ready", ld_ready, 0);
        chk("starve_gap_addr", mem_addr, 16'h0010);
        chk("starve_ram", ram[12'h040], 16'hA003);
`ifdef IMEM_ARB_PERF_EN
        chk("starve_perf_stall", perf_stall_cnt, 4);
        chk("starve_perf_grant", perf_grant_cnt, 1);
`endif
        nxt();

        // halted CPU: 10 consecutive writes, no stall
        fetch_req = 1'b0;
        ld_addr   = 16'h0100;
        ld_data   = 16'hC000;
        smp();
        chk("halt_lat_ready", ld_ready, 0);
        nxt();
        for (int k = 0; k < 10; k++) begin
            ld_addr = 16'h0100 + 16'(k);
            ld_data = 16'hC000 + 16'(k);
            smp();
            chk("halt_ready", ld_ready, 1);
            chk("halt_stall", fetch_stall, 0);
            chk("halt_we", mem_we, 1);
            chk("halt_addr", mem_addr, 16'h0100 + 16'(k));
            nxt();
        end
        ld_valid = 1'b0;
        smp();
        chk("halt_idle_we", mem_we, 0);
        chk("halt_ram0", ram[12'h100], 16'hC000);
        chk("halt_ram9", ram[12'h109], 16'hC009);
        nxt();

        // loader gap: drop after 2 writes, next grant waits again
        fetch_req = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = 16'h0200;
        ld_data   = 16'hD000;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("gap_wait1_ready", ld_ready, 0);
            nxt();
        end
        for (int k = 0; k < 2; k++) begin
            ld_addr = 16'h0200 + 16'(k);
            ld_data = 16'hD000 + 16'(k);
            smp();
            chk("gap_ready", ld_ready, 1);
            chk("gap_we", mem_we, 1);
            nxt();
        end
        ld_valid = 1'b0;
        smp();
        chk("gap_drop_we", mem_we, 0);
        chk("gap_drop_stall", fetch_stall, 1);
        nxt();
        ld_valid = 1'b1;
        ld_addr  = 16'h0210;
        ld_data  = 16'hD010;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("gap_wait2_ready", ld_ready, 0);
            chk("gap_wait2_stall", fetch_stall, 0);
            nxt();
        end
        smp();
        chk("gap_regrant_ready", ld_ready, 1);
        chk("gap_regrant_we", mem_we, 1);
        nxt();
        ld_valid = 1'b0;
        smp();
        nxt();

        // write to the current PC is visible after the stall
        fetch_addr = 16'h0020;
        ld_valid   = 1'b1;
        ld_addr    = 16'h0020;
        ld_data    = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            smp();
            nxt();
        end
        smp();
        chk("pc_we", mem_we, 1);
        chk("pc_stall", fetch_stall, 1);
        nxt();
        ld_valid = 1'b0;
        smp();
        chk("pc_hold_stall", fetch_stall, 1);
        nxt();
        smp();
        chk("pc_stall_fall", fetch_stall, 0);
        chk("pc_addr", mem_addr, 16'h0020);
        chk("pc_rdata", ram_rdata, 16'hBEEF);
`ifdef IMEM_ARB_PERF_EN
        chk("pc_perf_stall", perf_stall_cnt, 11);
        chk("pc_perf_grant", perf_grant_cnt, 5);
`endif
        nxt();

        // reset during the second write of a burst
        fetch_req = 1'b0;
        ld_valid  = 1'b1;
        ld_addr   = 16'h0300;
        ld_data   = 16'h1234;
        smp();
        nxt();
        smp();
        chk("rstb_first_we", mem_we, 1);
        nxt();
        ld_data = 16'h5678;
        rst_n   = 1'b0;
        smp();
        chk("rstb_we", mem_we, 0);
        chk("rstb_ready", ld_ready, 0);
        chk("rstb_addr", mem_addr, 16'h0020);
        nxt();
        rst_n     = 1'b1;
        fetch_req = 1'b1;
        smp();
        chk("rstb_state_ready", ld_ready, 0);
        chk("rstb_state_stall", fetch_stall, 0);
        chk("rstb_ram", ram[12'h300], 16'h1234);
`ifdef IMEM_ARB_PERF_EN
        chk("rstb_perf_stall", perf_stall_cnt, 0);
        chk("rstb_perf_grant", perf_grant_cnt, 0);
`endif
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single-port, 16-bit-wide instruction memory between two requesters: the CPU fetch stage, which reads every cycle, and the program loader/debug write port. The fetch stage has priority, but the loader is guaranteed a grant within a bounded wait and is limited to a bounded burst. While the loader owns the memory, the arbiter drives the fetch stage's STALL input so that the PC and the IF pipeline registers hold. The block sits between the fetch stage, the loader and the instruction RAM. The RAM has an asynchronous read and a synchronous write.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, instruction word width
- MAX_WAIT, 8, maximum cycles a pending loader request waits while fetch is active (≥1)
- BURST_MAX, 4, maximum consecutive loader writes per grant while fetch is active (≥1)

Ports. Reset rst_n is synchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fetch_req  in  1  fetch stage active; low means the CPU is halted
- fetch_addr  in  ADDR_W  PC from the fetch stage
- fetch_stall  out  1  stall to the fetch stage, ORed externally with other stall sources
- ld_valid  in  1  loader write request
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_ready  out  1  write accepted this cycle when ld_valid && ld_ready
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data

## Operation
- The FSM has two states, FETCH and LOAD. Outputs are decoded combinationally from the registered state.
- **In FETCH:**
  - mem_addr = fetch_addr, mem_we = 0, ld_ready = 0, fetch_stall = 0.
  - wait_cnt increments each cycle that ld_valid && fetch_req; otherwise it clears.
  - Go to LOAD when ld_valid && (!fetch_req || wait_cnt == MAX_WAIT-1).
- **In LOAD:**
  - mem_addr = ld_addr, mem_wdata = ld_data, mem_we = ld_valid && rst_n, ld_ready = 1, fetch_stall = fetch_req.
  - burst_cnt increments per accepted write.
  - Return to FETCH when !ld_valid, or when fetch_req && an accept occurs with burst_cnt == BURST_MAX-1.
  - On entering FETCH, wait_cnt and burst_cnt clear.
- **Halted CPU:** if fetch_req is low, the burst limit does not apply. LOAD persists while ld_valid is high.
- **fetch_req rises mid-burst:** burst_cnt keeps its current count. The limit then applies to that count.
- **Counter widths:** $clog2 of the respective bound, saturating-free, because each counter is bounded by its terminal compare.
- **No write-while-fetch hazard.** The fetch stage is stalled for the whole write. On return to FETCH it re-reads fetch_addr, so a write to the current PC is observed.
- **Reset:**
  - State = FETCH, counters = 0.
  - Outputs: fetch_stall = 0, ld_ready = 0, mem_we = 0, mem_addr = fetch_addr, mem_wdata = ld_data (combinational pass-through).
  - Reset asserted mid-burst: the write in that cycle is suppressed and the burst is abandoned. The loader must re-issue.

## Timing
- **Loader grant latency:**
  - 1 cycle after ld_valid when fetch_req is low.
  - At most MAX_WAIT cycles after ld_valid when fetch_req is high.
- **Fetch stall length:** at most BURST_MAX cycles per grant while fetch_req is high.
- **Between back-to-back loader grants:** at least 1 FETCH cycle.
- **ld_ready timing:** ld_ready asserts in the first LOAD cycle, so the first write lands at the end of that cycle.
- **Handshake:** the loader must hold ld_addr and ld_data stable while ld_valid && !ld_ready.
- **fetch_stall deassertion:** fetch_stall deasserts in the cycle the state returns to FETCH. IF captures the instruction at fetch_addr at the end of that cycle.

## Configuration
- IMEM_ARB_PERF_EN defined:
  - Adds output perf_stall_cnt [31:0], counting cycles with fetch_stall high.
  - Adds output perf_grant_cnt [15:0], counting FETCH→LOAD transitions.
  - Both counters wrap, and both reset to 0.
- IMEM_ARB_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package: the state enum (FETCH = 1'b0, LOAD = 1'b1) and the default MAX_WAIT/BURST_MAX constants.
- One sub-module, imem_arb_perf, holds the two counters. It is instantiated only under IMEM_ARB_PERF_EN.

## Test plan
- **Reset:** reset, then release with fetch_req = 1 and fetch_addr = 0x0010 → mem_addr = 0x0010, mem_we = 0, fetch_stall = 0, ld_ready = 0.
- **Starvation bound:** fetch_req = 1, ld_valid = 1 with ld_addr = 0x0040 held → LOAD is entered after exactly 8 cycles; fetch_stall = 1 and mem_we = 1 for 4 writes; then fetch_stall = 0 for at least 1 cycle.
- **Halted CPU:** fetch_req = 0, a 10-write burst to 0x0100..0x0109 → all 10 accepted on consecutive cycles, fetch_stall = 0 throughout.
- **Loader gap:** ld_valid drops after 2 writes → FETCH is re-entered the next cycle; the next grant waits again for up to 8 cycles.
- **Write to PC:** a write of 0xBEEF to fetch_addr 0x0020 → after fetch_stall falls, mem_addr = 0x0020 and the RAM returns 0xBEEF.
- **Reset mid-burst:** rst_n low during the 2nd write → mem_we = 0 that cycle; state = FETCH, and with IMEM_ARB_PERF_EN both counters read 0.
